nco_pwm_dac: RTL and testbench

Parametrised successor to the single-mode distance-to-FM DAC. It is a numerically controlled oscillator that drives a built-in PWM DAC, and it supports four selectable modes: mute, fixed tone, distance-driven FM, and linear sweep. The frequency step is computed arithmetically from distance, so no step LUT is needed. Sine samples come from an external quarter-wave ROM over a registered read port. The block sits between the distance measurement path and the audio/RF PWM output pin.

---
 rtl/nco_pwm_dac_if.sv | 13 +
 rtl/nco_pwm_dac.sv | 156 +++++++++++++++
 tb/tb_nco_pwm_dac.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/nco_pwm_dac_if.sv
// ROM read port between nco_pwm_dac and an external quarter-wave sine ROM.
//   rom_addr : quarter-wave address, driven by the DAC (master)
//   rom_data : unsigned amplitude, returned by the ROM (slave) one clock after rom_addr
interface nco_pwm_dac_if #(
  parameter int unsigned LUT_ADDR_WIDTH = 6,
  parameter int unsigned SINE_WIDTH     = 8
);
  logic [LUT_ADDR_WIDTH-1:0] rom_addr;
  logic [SINE_WIDTH-2:0]     rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/nco_pwm_dac.sv
// Numerically controlled oscillator feeding a PWM DAC. Modes: mute, fixed tone, distance-driven FM
// and linear sweep. Sine samples are rebuilt from a quarter-wave ROM behind a registered read port.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : clock enable, low freezes all state and silences the outputs
//   mode           : 00 mute, 01 tone, 10 FM, 11 sweep (sampled at period boundaries)
//   distance       : unsigned distance for FM (sampled at period boundaries)
//   rom            : quarter-wave ROM read port (master side)
//   sine_pwm_out   : PWM output
//   zero           : one-clock pulse at the start of every PWM period
module nco_pwm_dac #(
  parameter int unsigned DIST_WIDTH               = 13,
  parameter int unsigned SINE_WIDTH               = 8,
  parameter int unsigned PHASE_WIDTH              = 32,
  parameter int unsigned LUT_ADDR_WIDTH           = 6,
  parameter int unsigned COUNT_WIDTH              = 8,
  parameter int unsigned MAX_DIST                 = 2000,
  parameter logic [PHASE_WIDTH-1:0] CENTER_STEP   = 32'h0100_0000,
  parameter int unsigned GAIN_STEP                = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DIST_WIDTH-1:0] distance,
  nco_pwm_dac_if.master         rom,
  output logic                  sine_pwm_out,
  output logic                  zero
);

  localparam logic [1:0] ModeMute  = 2'b00;
  localparam logic [1:0] ModeTone  = 2'b01;
  localparam logic [1:0] ModeFm    = 2'b10;
  localparam logic [1:0] ModeSweep = 2'b11;

  localparam logic [SINE_WIDTH-1:0]  Mid      = {1'b1, {(SINE_WIDTH-1){1'b0}}};
  localparam logic [SINE_WIDTH-1:0]  MidM1    = Mid - 1'b1;
  localparam logic [DIST_WIDTH-1:0]  MaxDist  = DIST_WIDTH'(MAX_DIST);
  localparam logic [PHASE_WIDTH-1:0] GainStep = PHASE_WIDTH'(GAIN_STEP);
  // One extra bit so the sweep overflow test cannot wrap.
  localparam logic [PHASE_WIDTH:0]   SweepLimit = {1'b0, CENTER_STEP} +
      (PHASE_WIDTH+1)'(MAX_DIST) * (PHASE_WIDTH+1)'(GAIN_STEP);
  localparam int unsigned CmpWidth = (COUNT_WIDTH > SINE_WIDTH) ? COUNT_WIDTH : SINE_WIDTH;

  logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]    step_q, step_d;
  logic [1:0]                mode_q, mode_d;
  logic [PHASE_WIDTH-1:0]    sweep_acc_q, sweep_acc_d;
  logic [SINE_WIDTH-1:0]     duty_q, duty_d;
  logic [SINE_WIDTH-1:0]     sample_q, sample_d;
  logic [LUT_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                      pwm_q, pwm_d;
  logic                      zero_q, zero_d;

  logic                      boundary;
  logic [DIST_WIDTH-1:0]     d_sat;
  logic [PHASE_WIDTH-1:0]    fm_step;
  logic [PHASE_WIDTH:0]      sweep_next;
  logic [1:0]                quad;
  logic [LUT_ADDR_WIDTH-1:0] idx;
  logic [SINE_WIDTH-1:0]     rom_ext;

  assign boundary   = (cnt_q == '0);
  assign d_sat      = (distance > MaxDist) ? MaxDist : distance;
  assign fm_step    = CENTER_STEP + PHASE_WIDTH'(d_sat) * GainStep;
  assign sweep_next = {1'b0, sweep_acc_q} + {1'b0, GainStep};
  assign quad       = phase_q[PHASE_WIDTH-1 -: 2];
  assign idx        = phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
  assign rom_ext    = {1'b0, rom.rom_data};

  always_comb begin
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    step_d      = step_q;
    mode_d      = mode_q;
    sweep_acc_d = sweep_acc_q;
    duty_d      = duty_q;
    sample_d    = sample_q;
    rom_addr_d  = rom_addr_q;
    pwm_d       = 1'b0;
    zero_d      = 1'b0;

    if (enable) begin
      cnt_d  = cnt_q + 1'b1;
      zero_d = boundary;

      if (boundary) begin
        mode_d  = mode;
        // Phase advances by the step latched one boundary earlier.
        phase_d = phase_q + step_q;
        duty_d  = sample_q;
        unique case (mode)
          ModeMute:  step_d = '0;
          ModeTone:  step_d = CENTER_STEP;
          ModeFm:    step_d = fm_step;
          ModeSweep: step_d = sweep_acc_q;
        endcase
        // Outside sweep the accumulator sits at the base, so entering sweep restarts there.
        if (mode == ModeSweep) begin
          sweep_acc_d = (sweep_next > SweepLimit) ? CENTER_STEP : sweep_next[PHASE_WIDTH-1:0];
        end else begin
          sweep_acc_d = CENTER_STEP;
        end
      end

      // Odd quadrants read the table backwards.
      if (cnt_q == COUNT_WIDTH'(1)) begin
        rom_addr_d = quad[0] ? ~idx : idx;
      end

      // ROM data for the address issued at cnt==1 is present here.
      if (cnt_q == COUNT_WIDTH'(3)) begin
        if (mode_q == ModeMute) begin
          sample_d = Mid;
        end else begin
          sample_d = quad[1] ? (MidM1 - rom_ext) : (Mid + rom_ext);
        end
      end

      // Compare against the duty in force for this count so a period never mixes two duties.
      pwm_d = (CmpWidth'(cnt_q) < CmpWidth'(duty_d));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      step_q      <= '0;
      mode_q      <= ModeMute;
      sweep_acc_q <= CENTER_STEP;
      duty_q      <= Mid;
      sample_q    <= Mid;
      rom_addr_q  <= '0;
      pwm_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      sweep_acc_q <= sweep_acc_d;
      duty_q      <= duty_d;
      sample_q    <= sample_d;
      rom_addr_q  <= rom_addr_d;
      pwm_q       <= pwm_d;
      zero_q      <= zero_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign sine_pwm_out = pwm_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_nco_pwm_dac.sv
// Self-checking bench for nco_pwm_dac. A per-period reference model tracks phase, step, duty and
// sample from the mode/distance rules; each period the bench counts PWM high clocks (must equal the
// duty), checks the zero pulse and checks the ROM address issued for the current phase.
// MAX_DIST is reduced so a sweep wraps quickly; CENTER_STEP/GAIN_STEP are enlarged so the phase
// visits every quadrant and distance visibly moves the ROM address.
module tb_nco_pwm_dac;

  localparam int unsigned MaxDist = 100;
  localparam logic [31:0] Center  = 32'h0B00_0123;
  localparam int unsigned Gain    = 32'h0005_4321;
  localparam int unsigned Period  = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic [12:0] distance;
  logic        sine_pwm_out;
  logic        zero;

  nco_pwm_dac_if #(.LUT_ADDR_WIDTH(6), .SINE_WIDTH(8)) rom_if ();

  nco_pwm_dac #(
    .DIST_WIDTH     (13),
    .SINE_WIDTH     (8),
    .PHASE_WIDTH    (32),
    .LUT_ADDR_WIDTH (6),
    .COUNT_WIDTH    (8),
    .MAX_DIST       (MaxDist),
    .CENTER_STEP    (Center),
    .GAIN_STEP      (Gain)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .mode         (mode),
    .distance     (distance),
    .rom          (rom_if),
    .sine_pwm_out (sine_pwm_out),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  // Registered quarter-wave ROM: data follows the address by one clock.
  int unsigned rom_mem [64];
  always @(posedge clk) rom_if.rom_data <= 7'(rom_mem[rom_if.rom_addr]);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one update per period boundary.
  logic [31:0] m_phase;
  logic [31:0] m_step;
  int unsigned m_sweep_n;
  int unsigned m_duty;
  int unsigned m_sample;

  function automatic int unsigned addr_of(input logic [31:0] ph);
    int unsigned i = int'(ph[29:24]);
    return ph[30] ? (63 - i) : i;
  endfunction

  function automatic int unsigned sine_of(input logic [31:0] ph);
    int unsigned a = addr_of(ph);
    return ph[31] ? (127 - rom_mem[a]) : (128 + rom_mem[a]);
  endfunction

  task automatic model_reset();
    m_phase   = 32'd0;
    m_step    = 32'd0;
    m_sweep_n = 0;
    m_duty    = 128;
    m_sample  = 128;
  endtask

  task automatic model_boundary(input int unsigned md, input int unsigned d);
    int unsigned dsat = (d > MaxDist) ? MaxDist : d;
    m_phase = m_phase + m_step;
    m_duty  = m_sample;
    case (md)
      0:       m_step = 32'd0;
      1:       m_step = Center;
      2:       m_step = Center + dsat * Gain;
      default: m_step = Center + (m_sweep_n % (MaxDist + 1)) * Gain;
    endcase
    m_sweep_n = (md == 3) ? m_sweep_n + 1 : 0;
    m_sample  = (md == 0) ? 128 : sine_of(m_phase);
  endtask

  // Runs one PWM period starting at the boundary edge. nm/nd are applied mid-period for the next
  // boundary; gap > 0 drops enable for that many clocks mid-period.
  task automatic run_period(input logic [1:0] nm, input logic [12:0] nd, input int gap);
    int k = 0;
    int hi = 0;
    int zc = 0;
    int bad = 0;
    int gap_left = 0;
    logic en;
    logic [5:0] addr_hold = '0;
    model_boundary(int'(mode), int'(distance));
    while (k < int'(Period)) begin
      en = enable;
      @(posedge clk);
      #1;
      if (en) begin
        if (k == 0) check_eq("zero_pulse", 64'(zero), 64'd1);
        else zc += int'(zero);
        hi += int'(sine_pwm_out);
        if (k == 2) check_eq("rom_addr", 64'(rom_if.rom_addr), 64'(addr_of(m_phase)));
        if (k == 100) begin
          mode     = nm;
          distance = nd;
          if (gap > 0) begin
            enable    = 1'b0;
            gap_left  = gap;
            addr_hold = rom_if.rom_addr;
          end
        end
        k++;
      end else begin
        if (sine_pwm_out || zero) bad++;
        if (rom_if.rom_addr != addr_hold) bad++;
        gap_left--;
        if (gap_left == 0) enable = 1'b1;
      end
    end
    check_eq("duty_high_clks", 64'(hi), 64'(m_duty));
    check_eq("zero_extra", 64'(zc), 64'd0);
    if (gap > 0) check_eq("gap_quiet", 64'(bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = $rtoi(127.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 128.0) + 0.5);
    end
    reset_n  = 1'b0;
    enable   = 1'b1;
    mode     = 2'b01;
    distance = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pwm", 64'(sine_pwm_out), 64'd0);
    check_eq("rst_zero", 64'(zero), 64'd0);
    check_eq("rst_addr", 64'(rom_if.rom_addr), 64'd0);
    reset_n = 1'b1;
    model_reset();

    // Tone, then FM at fixed and saturating distances.
    for (int p = 0; p < 5; p++) run_period(2'b01, 13'd0, 0);
    run_period(2'b10, 13'd50, 0);
    run_period(2'b10, 13'd100, 0);
    run_period(2'b10, 13'd101, 0);
    run_period(2'b10, 13'd5000, 0);
    for (int p = 0; p < 4; p++) run_period(2'b10, 13'($urandom_range(0, 8191)), 0);
    run_period(2'b11, 13'd0, 0);

    // Sweep long enough to wrap, then leave and re-enter.
    for (int p = 0; p < 105; p++) run_period(2'b11, 13'($urandom_range(0, 8191)), 0);
    run_period(2'b01, 13'd0, 0);
    run_period(2'b11, 13'd0, 0);
    for (int p = 0; p < 4; p++) run_period(2'b11, 13'd0, 0);

    // Random mode/distance mix.
    for (int p = 0; p < 16; p++) begin
      run_period(2'($urandom_range(0, 3)), 13'($urandom_range(0, 8191)), 0);
    end

    // Mute, then tone with an enable gap.
    run_period(2'b00, 13'd0, 0);
    for (int p = 0; p < 3; p++) run_period(2'b00, 13'd0, 0);
    run_period(2'b01, 13'd0, 0);
    run_period(2'b01, 13'd0, 37);
    run_period(2'b01, 13'd0, 0);

    // Asynchronous reset mid-period.
    repeat (60) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    check_eq("arst_pwm", 64'(sine_pwm_out), 64'd0);
    check_eq("arst_zero", 64'(zero), 64'd0);
    check_eq("arst_addr", 64'(rom_if.rom_addr), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int p = 0; p < 3; p++) run_period(2'b01, 13'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
